// File: rtl/reg_write_queue.sv
// reg_write_queue
//   Write-side initiator for the 8x8 register file. ALU results (data plus
//   destination address) are buffered in a small FIFO. One entry per clock is
//   drained into the register-file write port (RF_IN / RF_INADDRESS / RF_WRITE).
//   Result production is decoupled from register-file commit, and the queue
//   absorbs pipeline stalls.
//
//   Optional feature: define REGQ_BYPASS_EN to enable the LOOKUP_* forwarding
//   search. Without it, the LOOKUP_* ports exist but are tied to zero.
//
// Ports
//   CLK           in   clock, all state on rising edge
//   RESET         in   asynchronous active-low reset
//   IN_DATA       in   result data from ALU
//   IN_ADDR       in   destination register
//   IN_VALID      in   push request
//   IN_READY      out  queue can accept (COUNT != DEPTH)
//   STALL         in   hold drain; pushes still accepted
//   FLUSH         in   synchronous discard of all pending entries
//   RF_WRITE      out  register-file WRITE
//   RF_INADDRESS  out  register-file INADDRESS
//   RF_IN         out  register-file IN
//   COUNT         out  pending entries (excludes entry on RF_*)
//   EMPTY         out  COUNT == 0
//   LOOKUP_ADDR   in   bypass query address
//   LOOKUP_HIT    out  a pending write to LOOKUP_ADDR exists
//   LOOKUP_DATA   out  youngest pending data for LOOKUP_ADDR
module reg_write_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [DATA_W-1:0]       IN_DATA,
    input  logic [ADDR_W-1:0]       IN_ADDR,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic                    STALL,
    input  logic                    FLUSH,
    output logic                    RF_WRITE,
    output logic [ADDR_W-1:0]       RF_INADDRESS,
    output logic [DATA_W-1:0]       RF_IN,
    output logic [$clog2(DEPTH):0]  COUNT,
    output logic                    EMPTY,
    input  logic [ADDR_W-1:0]       LOOKUP_ADDR,
    output logic                    LOOKUP_HIT,
    output logic [DATA_W-1:0]       LOOKUP_DATA
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    // IN_READY depends only on state, so it never forms a loop with IN_VALID.
    // A full queue refuses a push even when it pops on the same edge.
    assign IN_READY = (count != CNT_W'(DEPTH));

    // FLUSH discards a same-edge push and suppresses the pop.
    // A FLUSH therefore wins over a STALL.
    assign push = IN_VALID && IN_READY && !FLUSH;
    assign pop  = (count != '0) && !STALL && !FLUSH;

    assign COUNT = count;
    assign EMPTY = (count == '0);

    // NOTE: the storage array has no reset. Only the pointers and count define
    // which entries are valid, so clearing the array would add reset fan-out
    // for no functional gain.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= '{addr: IN_ADDR, data: IN_DATA};
        end
    end

    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the values that were present before the edge, whatever
    // the order of the statements.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            RF_WRITE     <= 1'b0;
            RF_IN        <= '0;
            RF_INADDRESS <= '0;
        end else begin
            // The RF_* outputs are registered. On cycles without a pop, the
            // data and address keep their last value.
            RF_WRITE <= pop;
            if (pop) begin
                RF_IN        <= mem[head].data;
                RF_INADDRESS <= mem[head].addr;
            end

            if (FLUSH) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

`ifdef REGQ_BYPASS_EN
    logic [PTR_W-1:0] scan_idx;

    // The scan runs from oldest to youngest, and each later match overwrites
    // an earlier one. The youngest pending write therefore wins. The entry on
    // RF_* is the oldest candidate, so it is loaded first.
    // NOTE: every output of a combinational block is given a default before
    // any conditional logic, so no path can leave it unassigned and infer
    // a latch.
    always_comb begin
        LOOKUP_HIT  = 1'b0;
        LOOKUP_DATA = '0;
        scan_idx    = head;
        if (RF_WRITE && (RF_INADDRESS == LOOKUP_ADDR)) begin
            LOOKUP_HIT  = 1'b1;
            LOOKUP_DATA = RF_IN;
        end
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem[scan_idx].addr == LOOKUP_ADDR)) begin
                LOOKUP_HIT  = 1'b1;
                LOOKUP_DATA = mem[scan_idx].data;
            end
        end
    end
`else
    logic unused_lookup;

    assign LOOKUP_HIT    = 1'b0;
    assign LOOKUP_DATA   = '0;
    assign unused_lookup = ^LOOKUP_ADDR;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// tb_reg_write_queue
//   Directed, self-checking bench for reg_write_queue. A small occupancy model
//   predicts COUNT, IN_READY and RF_WRITE. A scoreboard queue holds every
//   accepted push, and the bench pops it whenever the DUT drives a register
//   write.
module tb_reg_write_queue;

    localparam int DEPTH = 4;
`ifdef REGQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       CLK;
    logic       RESET;
    logic [7:0] IN_DATA;
    logic [2:0] IN_ADDR;
    logic       IN_VALID;
    logic       IN_READY;
    logic       STALL;
    logic       FLUSH;
    logic       RF_WRITE;
    logic [2:0] RF_INADDRESS;
    logic [7:0] RF_IN;
    logic [2:0] COUNT;
    logic       EMPTY;
    logic [2:0] LOOKUP_ADDR;
    logic       LOOKUP_HIT;
    logic [7:0] LOOKUP_DATA;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mdl_cnt  = 0;
    bit          mdl_rfw  = 1'b0;
    logic [10:0] sb [$];

    reg_write_queue #(.DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .IN_DATA      (IN_DATA),
        .IN_ADDR      (IN_ADDR),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .STALL        (STALL),
        .FLUSH        (FLUSH),
        .RF_WRITE     (RF_WRITE),
        .RF_INADDRESS (RF_INADDRESS),
        .RF_IN        (RF_IN),
        .COUNT        (COUNT),
        .EMPTY        (EMPTY),
        .LOOKUP_ADDR  (LOOKUP_ADDR),
        .LOOKUP_HIT   (LOOKUP_HIT),
        .LOOKUP_DATA  (LOOKUP_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model over the edge, and check
    // the DUT 1 ns after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] a,
                        input logic st, input logic fl);
        bit          push_ok;
        bit          pop_ok;
        logic [10:0] e;
        IN_VALID = v;
        IN_DATA  = d;
        IN_ADDR  = a;
        STALL    = st;
        FLUSH    = fl;
        @(posedge CLK);
        push_ok = v && (mdl_cnt != DEPTH) && !fl;
        pop_ok  = (mdl_cnt > 0) && !st && !fl;
        mdl_rfw = pop_ok;
        if (fl) begin
            mdl_cnt = 0;
            sb.delete();
        end else begin
            mdl_cnt = mdl_cnt + int'(push_ok) - int'(pop_ok);
            if (push_ok) sb.push_back({a, d});
        end
        #1;
        check("count",    32'(COUNT),    32'(mdl_cnt));
        check("empty",    32'(EMPTY),    32'(mdl_cnt == 0));
        check("in_ready", 32'(IN_READY), 32'(mdl_cnt != DEPTH));
        check("rf_write", 32'(RF_WRITE), 32'(mdl_rfw));
        if (mdl_rfw && sb.size() > 0) begin
            e = sb.pop_front();
            check("rf_entry", 32'({RF_INADDRESS, RF_IN}), 32'(e));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        RESET       = 1'b0;
        IN_DATA     = '0;
        IN_ADDR     = '0;
        IN_VALID    = 1'b0;
        STALL       = 1'b0;
        FLUSH       = 1'b0;
        LOOKUP_ADDR = 3'd0;
        #12;
        check("rst_rf_write", 32'(RF_WRITE),     32'd0);
        check("rst_rf_in",    32'(RF_IN),        32'd0);
        check("rst_rf_addr",  32'(RF_INADDRESS), 32'd0);
        check("rst_count",    32'(COUNT),        32'd0);
        check("rst_empty",    32'(EMPTY),        32'd1);
        check("rst_in_ready", 32'(IN_READY),     32'd1);
        RESET = 1'b1;

        // Single push: the write appears exactly one cycle, after the second edge.
        step(1'b1, 8'h06, 3'd2, 1'b0, 1'b0);
        check("t2_no_write_yet", 32'(RF_WRITE), 32'd0);
        idle(1);
        check("t2_write",  32'(RF_WRITE),     32'd1);
        check("t2_addr",   32'(RF_INADDRESS), 32'd2);
        check("t2_data",   32'(RF_IN),        32'h06);
        check("t2_empty",  32'(EMPTY),        32'd1);
        idle(1);
        check("t2_one_cycle", 32'(RF_WRITE),  32'd0);
        check("t2_hold_data", 32'(RF_IN),     32'h06);

        // Fill under stall, refuse the fifth push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h11 * (i + 1));
            step(1'b1, d, 3'(i), 1'b1, 1'b0);
        end
        check("t3_full_count", 32'(COUNT),    32'd4);
        check("t3_not_ready",  32'(IN_READY), 32'd0);
        step(1'b1, 8'h55, 3'd4, 1'b1, 1'b0);
        check("t3_drop_count", 32'(COUNT),    32'd4);
        idle(1);
        check("t3_first", 32'(RF_IN), 32'h11);
        idle(4);
        check("t3_last",  32'(RF_IN), 32'h44);

        // Simultaneous push and pop keeps the count.
        step(1'b1, 8'hA1, 3'd5, 1'b1, 1'b0);
        step(1'b1, 8'hA2, 3'd6, 1'b1, 1'b0);
        step(1'b1, 8'hA3, 3'd7, 1'b0, 1'b0);
        check("t4_count_same", 32'(COUNT), 32'd2);
        idle(4);

        // Flush with a push on the same edge. FLUSH wins over STALL.
        step(1'b1, 8'hB1, 3'd1, 1'b1, 1'b0);
        step(1'b1, 8'hB2, 3'd2, 1'b1, 1'b0);
        step(1'b1, 8'hB3, 3'd3, 1'b1, 1'b0);
        check("t5_count3", 32'(COUNT), 32'd3);
        step(1'b1, 8'hBB, 3'd4, 1'b1, 1'b1);
        check("t5_flush_count", 32'(COUNT),    32'd0);
        check("t5_flush_empty", 32'(EMPTY),    32'd1);
        check("t5_flush_write", 32'(RF_WRITE), 32'd0);
        idle(2);
        // An entry already on RF_* completes its write while the next pending entry is flushed.
        step(1'b1, 8'hC1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 3'd2, 1'b0, 1'b0);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        idle(2);

        // Bypass lookup
        LOOKUP_ADDR = 3'd3;
        step(1'b1, 8'hE6, 3'd3, 1'b1, 1'b0);
        step(1'b1, 8'h77, 3'd3, 1'b1, 1'b0);
        check("t6_hit",  32'(LOOKUP_HIT),  32'(BYP));
        check("t6_data", 32'(LOOKUP_DATA), BYP ? 32'h77 : 32'h0);
        LOOKUP_ADDR = 3'd5;
        #1;
        check("t6_miss", 32'(LOOKUP_HIT),  32'd0);
        LOOKUP_ADDR = 3'd3;
        idle(1);
        check("t6_hit_pend", 32'(LOOKUP_HIT),  32'(BYP));
        check("t6_data_pend", 32'(LOOKUP_DATA), BYP ? 32'h77 : 32'h0);
        idle(1);
        check("t6_hit_rf",  32'(LOOKUP_HIT),  32'(BYP));
        check("t6_data_rf", 32'(LOOKUP_DATA), BYP ? 32'h77 : 32'h0);
        idle(1);
        check("t6_gone", 32'(LOOKUP_HIT), 32'd0);

        // Reset mid-traffic takes effect immediately.
        step(1'b1, 8'hD1, 3'd1, 1'b1, 1'b0);
        step(1'b1, 8'hD2, 3'd2, 1'b1, 1'b0);
        step(1'b1, 8'hD3, 3'd3, 1'b0, 1'b0);
        check("t1_busy_write", 32'(RF_WRITE), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("t1_rf_write", 32'(RF_WRITE), 32'd0);
        check("t1_count",    32'(COUNT),    32'd0);
        check("t1_empty",    32'(EMPTY),    32'd1);
        check("t1_in_ready", 32'(IN_READY), 32'd1);
        #2;
        RESET   = 1'b1;
        mdl_cnt = 0;
        mdl_rfw = 1'b0;
        sb.delete();
        idle(2);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
